// File: rtl/ibex_rf_wb_buffer_pkg.sv
// Shared types for the writeback buffer and the register file write side.
// rf_wr_t is one register file write: destination, data, enable.
package ibex_rf_wb_buffer_pkg;

  localparam int unsigned RfDataWidth = 32;

  typedef struct packed {
    logic [4:0]             addr;
    logic [RfDataWidth-1:0] data;
    logic                   we;
  } rf_wr_t;

  typedef enum logic {
    TrkIdle,
    TrkWait
  } trk_state_e;

  // Read address matches a live destination.
  function automatic logic rf_hit(input logic [4:0] raddr, input logic vld,
                                  input logic [4:0] waddr);
    return vld && (raddr == waddr);
  endfunction

endpackage

// File: rtl/ibex_rf_wb_buffer_if.sv
// EX result, LSU load and register file write signals of the writeback buffer.
// The slave modport is the buffer; the master modport is its environment.
interface ibex_rf_wb_buffer_if #(
  parameter int unsigned DataWidth = 32
);
  logic                 ex_valid_i;
  logic                 ex_ready_o;
  logic [4:0]           ex_waddr_i;
  logic [DataWidth-1:0] ex_wdata_i;

  logic                 lsu_req_i;
  logic [4:0]           lsu_req_waddr_i;
  logic                 lsu_rvalid_i;
  logic [DataWidth-1:0] lsu_rdata_i;
  logic                 lsu_err_i;

  logic [4:0]           rf_waddr_o;
  logic [DataWidth-1:0] rf_wdata_o;
  logic                 rf_we_o;

  modport slave (
    input  ex_valid_i, ex_waddr_i, ex_wdata_i,
    input  lsu_req_i, lsu_req_waddr_i, lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
    output ex_ready_o, rf_waddr_o, rf_wdata_o, rf_we_o
  );

  modport master (
    output ex_valid_i, ex_waddr_i, ex_wdata_i,
    output lsu_req_i, lsu_req_waddr_i, lsu_rvalid_i, lsu_rdata_i, lsu_err_i,
    input  ex_ready_o, rf_waddr_o, rf_wdata_o, rf_we_o
  );
endinterface

// File: rtl/ibex_rf_wb_buffer.sv
// Merges EX results and load responses into the single register file write port.
// Loads win; a colliding EX result waits one slot in the hold register.
module ibex_rf_wb_buffer
  import ibex_rf_wb_buffer_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = RfDataWidth
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  ibex_rf_wb_buffer_if.slave  bus,
  input  logic [4:0]          raddr_a_i,
  input  logic [4:0]          raddr_b_i,
  output logic                hazard_a_o,
  output logic                hazard_b_o,
  output logic                busy_o
);

  trk_state_e           trk_state;
  logic [4:0]           pend_addr;
  logic                 pend_valid;

  rf_wr_t               out_q;
  rf_wr_t               hold_q;
  logic                 hold_valid;

  logic                 ex_acc;
  logic                 load_wr;
  logic [DataWidth-1:0] ex_data;
  logic [DataWidth-1:0] ld_data;
  rf_wr_t               ex_wr;
  rf_wr_t               ld_wr;

  assign pend_valid = (trk_state == TrkWait);
  assign ex_acc     = bus.ex_valid_i && !hold_valid;
  assign load_wr    = bus.lsu_rvalid_i && !bus.lsu_err_i;
  assign ex_data    = bus.ex_wdata_i;
  assign ld_data    = bus.lsu_rdata_i;

  // x0 travels through the pipe like any other result but never enables a write.
  assign ex_wr = '{addr: bus.ex_waddr_i, data: ex_data, we: bus.ex_waddr_i != 5'd0};
  assign ld_wr = '{addr: pend_addr,      data: ld_data, we: pend_addr != 5'd0};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q      <= '0;
      hold_q     <= '0;
      hold_valid <= 1'b0;
    end else begin
      out_q.we <= 1'b0;
      if (load_wr) begin
        out_q <= ld_wr;
      end else if (hold_valid) begin
        out_q <= hold_q;
      end else if (ex_acc) begin
        out_q <= ex_wr;
      end

      // ex_acc implies the slot is empty, so capture and drain never overlap.
      if (ex_acc && load_wr) begin
        hold_q     <= ex_wr;
        hold_valid <= 1'b1;
      end else if (hold_valid && !load_wr) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // At most one load is outstanding; a response may retire it while a new one issues.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trk_state <= TrkIdle;
      pend_addr <= 5'd0;
    end else begin
      case (trk_state)
        TrkIdle: begin
          if (bus.lsu_req_i) begin
            trk_state <= TrkWait;
            pend_addr <= bus.lsu_req_waddr_i;
          end
        end
        TrkWait: begin
          if (bus.lsu_req_i) begin
            pend_addr <= bus.lsu_req_waddr_i;
          end else if (bus.lsu_rvalid_i) begin
            trk_state <= TrkIdle;
          end
        end
        default: trk_state <= TrkIdle;
      endcase
    end
  end

  assign bus.ex_ready_o = !hold_valid;
  assign bus.rf_waddr_o = out_q.addr;
  assign bus.rf_wdata_o = out_q.data;
  assign bus.rf_we_o    = out_q.we;

  assign hazard_a_o = (raddr_a_i != 5'd0) &&
                      (rf_hit(raddr_a_i, pend_valid, pend_addr) ||
                       rf_hit(raddr_a_i, hold_valid, hold_q.addr) ||
                       rf_hit(raddr_a_i, out_q.we, out_q.addr));
  assign hazard_b_o = (raddr_b_i != 5'd0) &&
                      (rf_hit(raddr_b_i, pend_valid, pend_addr) ||
                       rf_hit(raddr_b_i, hold_valid, hold_q.addr) ||
                       rf_hit(raddr_b_i, out_q.we, out_q.addr));

  assign busy_o = hold_valid || pend_valid || out_q.we;

  a_req_while_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus.lsu_req_i && pend_valid && !bus.lsu_rvalid_i));
  a_rvalid_while_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus.lsu_rvalid_i && !pend_valid));
  a_no_x0_write: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus.rf_we_o && (bus.rf_waddr_o == 5'd0)));

  if (RV32E) begin : g_rv32e_chk
    a_ex_addr_e: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.ex_valid_i && bus.ex_waddr_i[4]));
    a_ld_addr_e: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.lsu_req_i && bus.lsu_req_waddr_i[4]));
  end

endmodule

// File: tb/tb_ibex_rf_wb_buffer.sv
// Directed and randomized bench for the writeback buffer against a queue-based
// model: pending EX results form a FIFO that load responses may bypass.
module tb_ibex_rf_wb_buffer;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [4:0] raddr_a_i, raddr_b_i;
  logic       hazard_a_o, hazard_b_o, busy_o;

  int n_checks = 0;
  int n_errors = 0;

  ibex_rf_wb_buffer_if #(.DataWidth(32)) bus ();

  ibex_rf_wb_buffer #(.RV32E(1'b0), .DataWidth(32)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .bus        (bus),
    .raddr_a_i  (raddr_a_i),
    .raddr_b_i  (raddr_b_i),
    .hazard_a_o (hazard_a_o),
    .hazard_b_o (hazard_b_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } res_t;

  // Reference model state
  res_t        wq[$];
  logic        m_pend_v;
  logic [4:0]  m_pend_a;
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_hazard(input logic [4:0] r);
    logic h;
    h = (m_pend_v && r == m_pend_a) || (m_we && r == m_wa);
    if (wq.size() > 0) h = h || (r == wq[0].a);
    return (r != 5'd0) && h;
  endfunction

  task automatic model_reset();
    wq.delete();
    m_pend_v = 1'b0;
    m_pend_a = 5'd0;
    m_we     = 1'b0;
    m_wa     = 5'd0;
    m_wd     = 32'd0;
  endtask

  // One clock of the model, using the inputs currently driven.
  task automatic model_clock();
    res_t r;
    logic wrote;
    wrote = 1'b0;
    if (bus.ex_valid_i && wq.size() == 0) wq.push_back('{a: bus.ex_waddr_i, d: bus.ex_wdata_i});
    if (bus.lsu_rvalid_i && !bus.lsu_err_i) begin
      m_wa = m_pend_a; m_wd = bus.lsu_rdata_i; wrote = 1'b1;
    end else if (wq.size() > 0) begin
      r = wq.pop_front();
      m_wa = r.a; m_wd = r.d; wrote = 1'b1;
    end
    m_we = wrote && (m_wa != 5'd0);
    if (bus.lsu_req_i) begin
      m_pend_v = 1'b1; m_pend_a = bus.lsu_req_waddr_i;
    end else if (bus.lsu_rvalid_i) begin
      m_pend_v = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("rf_we", bus.rf_we_o, m_we);
    if (m_we) begin
      chk("rf_waddr", bus.rf_waddr_o, m_wa);
      chk("rf_wdata", bus.rf_wdata_o, m_wd);
    end
    chk("ex_ready", bus.ex_ready_o, wq.size() == 0);
    chk("hazard_a", hazard_a_o, m_hazard(raddr_a_i));
    chk("hazard_b", hazard_b_o, m_hazard(raddr_b_i));
    chk("busy", busy_o, m_pend_v || m_we || wq.size() > 0);
  endtask

  task automatic cycle();
    model_clock();
    @(posedge clk_i);
    #1;
    check_all();
  endtask

  task automatic idle();
    bus.ex_valid_i   = 1'b0;
    bus.lsu_req_i    = 1'b0;
    bus.lsu_rvalid_i = 1'b0;
    bus.lsu_err_i    = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, bus.rf_we_o, 1'b0);
    chk({tag, "_waddr"}, bus.rf_waddr_o, 5'd0);
    chk({tag, "_wdata"}, bus.rf_wdata_o, 32'd0);
    chk({tag, "_ready"}, bus.ex_ready_o, 1'b1);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_haz_a"}, hazard_a_o, 1'b0);
  endtask

  initial begin
    idle();
    bus.ex_waddr_i = 5'd0; bus.ex_wdata_i = 32'd0;
    bus.lsu_req_waddr_i = 5'd0; bus.lsu_rdata_i = 32'd0;
    raddr_a_i = 5'd1; raddr_b_i = 5'd2;
    model_reset();
    #12;
    chk_reset_outputs("reset");
    chk("reset_haz_b", hazard_b_o, 1'b0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // EX only
    bus.ex_valid_i = 1'b1; bus.ex_waddr_i = 5'd5; bus.ex_wdata_i = 32'h1234_5678;
    cycle();
    chk("exonly_we", bus.rf_we_o, 1'b1);
    chk("exonly_addr", bus.rf_waddr_o, 5'd5);
    chk("exonly_data", bus.rf_wdata_o, 32'h1234_5678);
    idle();
    cycle();
    chk("exonly_we_n2", bus.rf_we_o, 1'b0);

    // Collision: load x7 and EX x3 at the same edge
    bus.lsu_req_i = 1'b1; bus.lsu_req_waddr_i = 5'd7;
    cycle();
    idle();
    bus.lsu_rvalid_i = 1'b1; bus.lsu_rdata_i = 32'hAAAA_0000;
    bus.ex_valid_i = 1'b1; bus.ex_waddr_i = 5'd3; bus.ex_wdata_i = 32'h11;
    cycle();
    chk("coll_ld_addr", bus.rf_waddr_o, 5'd7);
    chk("coll_ld_data", bus.rf_wdata_o, 32'hAAAA_0000);
    chk("coll_ready_n1", bus.ex_ready_o, 1'b0);
    idle();
    cycle();
    chk("coll_ex_we", bus.rf_we_o, 1'b1);
    chk("coll_ex_addr", bus.rf_waddr_o, 5'd3);
    chk("coll_ex_data", bus.rf_wdata_o, 32'h11);
    chk("coll_ready_n2", bus.ex_ready_o, 1'b1);

    // Load hazard on x9
    raddr_a_i = 5'd9;
    bus.lsu_req_i = 1'b1; bus.lsu_req_waddr_i = 5'd9;
    cycle();
    chk("ldhaz_n1", hazard_a_o, 1'b1);
    idle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("ldhaz_wait", hazard_a_o, 1'b1);
    end
    bus.lsu_rvalid_i = 1'b1; bus.lsu_rdata_i = 32'hCAFE_0009;
    cycle();
    chk("ldhaz_n5_we", bus.rf_we_o, 1'b1);
    chk("ldhaz_n5_addr", bus.rf_waddr_o, 5'd9);
    idle();
    cycle();
    chk("ldhaz_n6", hazard_a_o, 1'b0);

    // Load error
    bus.lsu_req_i = 1'b1; bus.lsu_req_waddr_i = 5'd4;
    cycle();
    idle();
    bus.lsu_rvalid_i = 1'b1; bus.lsu_err_i = 1'b1; bus.lsu_rdata_i = 32'hDEAD_BEEF;
    cycle();
    chk("lderr_we", bus.rf_we_o, 1'b0);
    chk("lderr_busy", busy_o, 1'b0);
    idle();

    // x0 destination
    raddr_a_i = 5'd0;
    bus.ex_valid_i = 1'b1; bus.ex_waddr_i = 5'd0; bus.ex_wdata_i = 32'hFFFF_FFFF;
    #1 chk("x0_ready", bus.ex_ready_o, 1'b1);
    cycle();
    chk("x0_we", bus.rf_we_o, 1'b0);
    chk("x0_haz", hazard_a_o, 1'b0);
    idle();
    cycle();

    // Reset while the hold slot is occupied
    raddr_a_i = 5'd3;
    bus.lsu_req_i = 1'b1; bus.lsu_req_waddr_i = 5'd7;
    cycle();
    idle();
    bus.lsu_rvalid_i = 1'b1; bus.lsu_rdata_i = 32'h5555_0007;
    bus.ex_valid_i = 1'b1; bus.ex_waddr_i = 5'd3; bus.ex_wdata_i = 32'h33;
    cycle();
    chk("rst_hold_ready", bus.ex_ready_o, 1'b0);
    idle();
    #2 rst_ni = 1'b0;
    #1 chk_reset_outputs("midrst");
    model_reset();
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("postrst_we", bus.rf_we_o, 1'b0);
    end

    // Randomized traffic within the load protocol
    for (int i = 0; i < 600; i++) begin
      if (!(bus.ex_valid_i && !bus.ex_ready_o)) begin
        bus.ex_valid_i = ($urandom_range(0, 9) < 6);
        bus.ex_waddr_i = 5'($urandom_range(0, 7));
        bus.ex_wdata_i = $urandom;
      end
      bus.lsu_rvalid_i = m_pend_v && ($urandom_range(0, 1) == 1);
      bus.lsu_err_i    = bus.lsu_rvalid_i && ($urandom_range(0, 4) == 0);
      bus.lsu_rdata_i  = $urandom;
      bus.lsu_req_i    = (!m_pend_v || bus.lsu_rvalid_i) && ($urandom_range(0, 9) < 4);
      bus.lsu_req_waddr_i = 5'($urandom_range(0, 7));
      raddr_a_i = 5'($urandom_range(0, 7));
      raddr_b_i = 5'($urandom_range(0, 7));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
